// File: rtl/uart_tx.sv
// uart_tx: LSB-first asynchronous serial transmitter.
// Takes one byte over a VALID/READY handshake and sends it as a
// start / data / optional parity / stop frame on a registered TX line.
module uart_tx #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [DATA_BITS-1:0] DATA,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 TX,
    output logic                 DONE
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic              HAS_PARITY = (PARITY != 0);
    localparam logic              PARITY_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state, state_next;
    logic [BAUD_W-1:0]    baud_cnt, baud_cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 parity_bit, parity_bit_next;
    logic                 tx_reg, tx_next;
    logic                 done_reg, done_next;
    logic                 baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign READY    = (state == ST_IDLE);
    assign TX       = tx_reg;
    assign DONE     = done_reg;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shreg      <= shreg_next;
            parity_bit <= parity_bit_next;
            tx_reg     <= tx_next;
            done_reg   <= done_next;
        end
    end

    // Next-state and next-line-level logic; TX is computed one bit ahead
    // so the registered line changes exactly on bit boundaries.
    always_comb begin
        state_next      = state;
        baud_cnt_next   = baud_cnt;
        bit_cnt_next    = bit_cnt;
        shreg_next      = shreg;
        parity_bit_next = parity_bit;
        tx_next         = tx_reg;
        done_next       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (VALID) begin
                    state_next      = ST_START;
                    shreg_next      = DATA;
                    parity_bit_next = (^DATA) ^ PARITY_ODD;
                    baud_cnt_next   = '0;
                    tx_next         = 1'b0;
                end
            end

            ST_START: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = ST_DATA;
                    tx_next       = shreg[0];
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    shreg_next    = {1'b0, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
                        if (HAS_PARITY) begin
                            state_next = ST_PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        tx_next      = shreg[1];
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end

            ST_PARITY: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = ST_STOP;
                    tx_next       = 1'b1;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    baud_cnt_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = ST_IDLE;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + random frames on four uart_tx configurations,
// compared cycle by cycle against a frame-level bit list model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] tx;
    logic [3:0] done;
    logic [7:0] data [4];

    int cd  [4] = '{4, 4, 4, 2};
    int db  [4] = '{8, 8, 8, 5};
    int par [4] = '{0, 1, 2, 0};
    int stp [4] = '{1, 1, 1, 2};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .CLK(clk), .RESET_N(rst_n), .DATA(data[0]), .VALID(valid[0]),
        .READY(ready[0]), .TX(tx[0]), .DONE(done[0]));
    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .CLK(clk), .RESET_N(rst_n), .DATA(data[1]), .VALID(valid[1]),
        .READY(ready[1]), .TX(tx[1]), .DONE(done[1]));
    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .CLK(clk), .RESET_N(rst_n), .DATA(data[2]), .VALID(valid[2]),
        .READY(ready[2]), .TX(tx[2]), .DONE(done[2]));
    uart_tx #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
        .CLK(clk), .RESET_N(rst_n), .DATA(data[3][4:0]), .VALID(valid[3]),
        .READY(ready[3]), .TX(tx[3]), .DONE(done[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after a negedge. Sends one frame and checks every cycle
    // of it plus the DONE cycle. Leaves VALID high when hold is set.
    task automatic send(input int idx, input logic [7:0] b, input bit hold);
        bit q[$];
        int w;
        int n;
        int ones;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < db[idx]; i++) begin
            q.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (par[idx] == 1) q.push_back(ones % 2 == 1);
        if (par[idx] == 2) q.push_back(ones % 2 == 0);
        for (int s = 0; s < stp[idx]; s++) q.push_back(1'b1);

        data[idx]  = b;
        valid[idx] = 1'b1;
        w = 0;
        while (ready[idx] !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            check("accept_timeout", 32'd0, 32'd1);
            valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc[idx] = cyc;
        if (!hold) valid[idx] = 1'b0;
        data[idx] = 8'($urandom);

        n = q.size() * cd[idx];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("tx_bit", 32'(tx[idx]), 32'(q[k / cd[idx]]));
            check("ready_busy", 32'(ready[idx]), 32'd0);
            check("done_busy", 32'(done[idx]), 32'd0);
        end
        @(negedge clk);
        check("tx_end", 32'(tx[idx]), 32'd1);
        check("ready_end", 32'(ready[idx]), 32'd1);
        check("done_pulse", 32'(done[idx]), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0;
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;

        // Reset held 3 cycles, then idle for 100 cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check("idle_tx", 32'(tx[i]), 32'd1);
                check("idle_ready", 32'(ready[i]), 32'd1);
                check("idle_done", 32'(done[i]), 32'd0);
            end
        end

        // Single frame, no parity.
        send(0, 8'hA5, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(done[0]), 32'd0);

        // Even and odd parity on 0x07.
        send(1, 8'h07, 1'b0);
        send(2, 8'h07, 1'b0);

        // Back-to-back with VALID held, DATA scrambled mid-frame.
        send(0, 8'h55, 1'b1);
        a0 = acc_cyc[0];
        send(0, 8'h0F, 1'b0);
        check("b2b_spacing", 32'(acc_cyc[0] - a0), 32'd41);

        // Reset during data bit 3 of 0xFF.
        @(negedge clk);
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("mid_before_rst_ready", 32'(ready[0]), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(tx[0]), 32'd1);
        check("rst_mid_ready", 32'(ready[0]), 32'd1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done[0]), 32'd0);
            check("rst_idle_tx", 32'(tx[0]), 32'd1);
        end
        send(0, 8'h00, 1'b0);

        // Narrow, fast, two-stop configuration.
        send(3, 8'h1F, 1'b0);

        // Random bytes on every configuration.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                send(i, 8'($urandom), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
LSB-first asynchronous serial transmitter. It is the transmit-side counterpart of the team's serial receive path, which is built from sync, edetect and shift_reg_lf. It accepts one parallel byte over a valid/ready handshake and drives it out as a start/data/parity/stop frame on a single line. It sits between the CPU-side I/O register logic and the TX pin of the telemetry link.

Parameters:
CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
DATA_BITS, 8, number of data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
RESET_N  input  1  synchronous, active-low reset.
DATA  input  DATA_BITS  byte to send; sampled only on an accepted handshake.
VALID  input  1  requester has DATA ready.
READY  output  1  transmitter idle and able to accept a byte.
TX  output  1  serial line; idle high; registered output.
DONE  output  1  one-cycle pulse when a frame's final stop bit completes.

Behaviour:
- Reset (RESET_N=0 at a rising edge): state IDLE, TX=1, READY=1, DONE=0, baud and bit counters 0, shift register 0. Reset has priority over everything else.
- Reset mid-frame: the frame is abandoned and TX returns to 1 after that edge. No DONE is produced.
- Handshake: a transfer is accepted at an edge where VALID=1 and READY=1. DATA is latched into the internal shift register on that edge.
- READY is 1 only in IDLE. While READY=0, VALID and DATA are ignored. Changes to DATA during a frame have no effect.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> PARITY (if PARITY != 0) or STOP after DATA_BITS bit periods.
  - PARITY -> STOP after CLK_DIV cycles.
  - STOP -> IDLE after STOP_BITS*CLK_DIV cycles.
- Line levels:
  - START drives TX=0.
  - DATA drives the shift register LSB, then shifts right once per bit period.
  - PARITY drives even parity = XOR of the data bits; odd parity = its inverse.
  - STOP and IDLE drive TX=1.
- Timing, with N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS:
  - TX falls on the accept edge itself (registered, visible the following cycle).
  - Every bit is held exactly CLK_DIV cycles.
  - At edge accept+N*CLK_DIV the state is IDLE, READY=1, and DONE=1 for exactly that one cycle.
- Back-to-back: with VALID held high, the next accept happens one edge after READY rises. Start edges are therefore N*CLK_DIV+1 cycles apart (one extra idle-high cycle).
- Baud counter: width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary. It is cleared on accept.
- Bit counter: width $clog2(DATA_BITS+1). It is cleared on entry to DATA.
- Parity is computed from the latched byte at accept, not from the live DATA input.
- No glitches on TX: it changes only at bit boundaries.

Test Plan:
1. Reset and idle: hold RESET_N=0 for 3 cycles, then release with VALID=0 -> TX=1, READY=1, DONE=0 continuously for 100 cycles.
2. Single frame: CLK_DIV=4, PARITY=0, STOP_BITS=1; send 0xA5 -> TX sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. READY low for exactly 40 cycles. DONE high for exactly one cycle, coincident with READY rising.
3. Parity: CLK_DIV=4, PARITY=1; send 0x07 -> the parity bit is 1. With PARITY=2 the parity bit is 0. Frame length is 44 cycles.
4. Back-to-back with busy blocking: VALID held high with 0x55 then 0x0F; toggle DATA mid-frame -> both frames are exact. Start edges are 41 cycles apart. The mid-frame DATA change has no effect.
5. Reset mid-frame: assert RESET_N=0 during data bit 3 of 0xFF -> TX=1 and READY=1 after that edge, and no DONE pulse. The next frame 0x00 is sent correctly.
6. Boundary: CLK_DIV=2, DATA_BITS=5, STOP_BITS=2; send 5'h1F -> bits 0,1,1,1,1,1,1,1, each held 2 cycles. Total 16 cycles, then DONE.
